// File: rtl/node_rx_module.sv
`default_nettype none
// ============================================================================
// Module      : node_rx_module
// Description : Receive-side node controller. Accepts one packet per IF
//               request, buffers its payload words, checks header
//               consistency and streams payloads to the local PE over a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module node_rx_module #(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        N_clk,
  input  logic        N_rst,
  input  logic [7:0]  Node_local_id,
  input  logic        If_req_rx,
  output logic        If_ack_rx,
  input  logic [63:0] If_data_input,
  input  logic        If_data_input_valid,
  output logic        Pe_o_valid,
  input  logic        Pe_i_ready,
  output logic [31:0] Pe_o_data,
  output logic [7:0]  Pe_o_src,
  output logic [5:0]  Pe_o_id,
  output logic        Pe_o_last,
  output logic        Err_hdr,
  output logic        Err_ovf,
  output logic        Err_timeout,
  output logic [15:0] Pkt_count
);

  localparam int unsigned AW          = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [6:0]  C_MAX_WORDS = 7'(MAX_WORDS);
  localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ACK   = 2'd1,
    R_RECV  = 2'd2,
    R_DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    wr_cnt_q, wr_cnt_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    src_q, src_d;
  logic [5:0]    id_q, id_d;
  logic [5:0]    len_q, len_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          err_hdr_q, err_hdr_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_timeout_q, err_timeout_d;
  logic [15:0]   pkt_count_q, pkt_count_d;

  logic [31:0]   pld_mem [MAX_WORDS];
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  // Incoming word fields
  logic [7:0]  in_src, in_dst;
  logic [5:0]  in_len, in_id;
  logic [31:0] in_pld;
  logic        unused_rsvd;
  assign in_src      = If_data_input[63:56];
  assign in_dst      = If_data_input[55:48];
  assign in_len      = If_data_input[47:42];
  assign in_id       = If_data_input[41:36];
  assign in_pld      = If_data_input[31:0];
  assign unused_rsvd = ^If_data_input[35:32];

  // The first word defines the header; later words are compared against it
  logic       first_word;
  logic [5:0] len_eff;
  logic [6:0] drain_len;
  assign first_word = (wr_cnt_q == 7'd0);
  assign len_eff    = first_word ? in_len : len_q;
  // Oversized packets are truncated to the buffer depth on the PE side
  assign drain_len  = ({1'b0, len_q} > C_MAX_WORDS) ? C_MAX_WORDS : {1'b0, len_q};

  // Outputs decoded from registered state; data gated so idle output is 0
  assign If_ack_rx   = (state_q == R_ACK);
  assign Pe_o_valid  = (state_q == R_DRAIN);
  assign Pe_o_data   = Pe_o_valid ? pld_mem[rd_ptr_q] : 32'd0;
  assign Pe_o_src    = src_q;
  assign Pe_o_id     = id_q;
  assign Pe_o_last   = Pe_o_valid && ({{(7-AW){1'b0}}, rd_ptr_q} == (drain_len - 7'd1));
  assign Err_hdr     = err_hdr_q;
  assign Err_ovf     = err_ovf_q;
  assign Err_timeout = err_timeout_q;
  assign Pkt_count   = pkt_count_q;

  // Next-state, capture and error-pulse logic
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    timer_d       = timer_q;
    src_d         = src_q;
    id_d          = id_q;
    len_d         = len_q;
    rd_ptr_d      = rd_ptr_q;
    err_hdr_d     = 1'b0;
    err_ovf_d     = 1'b0;
    err_timeout_d = 1'b0;
    pkt_count_d   = pkt_count_q;
    wr_en         = 1'b0;
    wr_addr       = wr_cnt_q[AW-1:0];
    unique case (state_q)
      R_IDLE: begin
        if (If_req_rx) state_d = R_ACK;
      end
      R_ACK: begin
        state_d  = R_RECV;
        wr_cnt_d = 7'd0;
        timer_d  = 16'd0;
      end
      R_RECV: begin
        if (If_data_input_valid) begin
          timer_d = 16'd0;
          if (first_word) begin
            src_d = in_src;
            id_d  = in_id;
            len_d = in_len;
          end
          if (first_word && (in_len == 6'd0)) begin
            // Zero-length header: nothing to deliver
            err_hdr_d = 1'b1;
            state_d   = R_IDLE;
          end else begin
            // Mismatching words are still stored and counted
            err_hdr_d = (in_dst != Node_local_id) ||
                        (!first_word && ((in_src != src_q) || (in_id != id_q) ||
                                         (in_len != len_q)));
            err_ovf_d = first_word && ({1'b0, in_len} > C_MAX_WORDS);
            wr_en     = (wr_cnt_q < C_MAX_WORDS);
            wr_cnt_d  = wr_cnt_q + 7'd1;
            if ((wr_cnt_q + 7'd1) == {1'b0, len_eff}) begin
              state_d  = R_DRAIN;
              rd_ptr_d = '0;
            end
          end
        end else begin
          timer_d = timer_q + 16'd1;
          if (timer_d == C_TIMEOUT) begin
            err_timeout_d = 1'b1;
            state_d       = R_IDLE;
          end
        end
      end
      R_DRAIN: begin
        if (Pe_i_ready) begin
          if (Pe_o_last) begin
            state_d     = R_IDLE;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Control and header registers with asynchronous active-low reset
  always_ff @(posedge N_clk or negedge N_rst) begin
    if (!N_rst) begin
      state_q       <= R_IDLE;
      wr_cnt_q      <= 7'd0;
      timer_q       <= 16'd0;
      src_q         <= 8'd0;
      id_q          <= 6'd0;
      len_q         <= 6'd0;
      rd_ptr_q      <= '0;
      err_hdr_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      pkt_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      timer_q       <= timer_d;
      src_q         <= src_d;
      id_q          <= id_d;
      len_q         <= len_d;
      rd_ptr_q      <= rd_ptr_d;
      err_hdr_q     <= err_hdr_d;
      err_ovf_q     <= err_ovf_d;
      err_timeout_q <= err_timeout_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  // Payload buffer; contents need no reset
  always_ff @(posedge N_clk) begin
    if (wr_en) pld_mem[wr_addr] <= in_pld;
  end

endmodule
`default_nettype wire

// File: doc/node_rx_module.md
Name: node_rx_module

Overview:
- Receive-side node controller; the consumer end of the IF-to-PE receive handshake (o_req_rx / i_ack_rx / o_data_input / o_data_input_valid) of m_if_2_router_v3.
- Accepts one packet per request, buffers its payload words, checks header consistency, then streams payloads to the local PE over a valid/ready port.
- Sits in the node beside the send-side logic, one instance per node.

Parameters:
MAX_WORDS, 8, buffer depth in 32-bit payload words (power of 2, 2..32)
TIMEOUT, 255, idle cycles allowed between words in RECV before the packet is aborted (1..65535)

Ports:
N_clk  in  1  clock, rising edge
N_rst  in  1  reset, asynchronous, active-low
Node_local_id  in  8  this node's id; word dst checked against it
If_req_rx  in  1  IF has a packet ready (level)
If_ack_rx  out  1  one-cycle accept pulse to IF
If_data_input  in  64  [63:56] src, [55:48] dst, [47:42] seq_len, [41:36] id, [35:32] rsvd, [31:0] payload
If_data_input_valid  in  1  word valid, one word per cycle
Pe_o_valid  out  1  payload word valid to PE
Pe_i_ready  in  1  PE accepts word
Pe_o_data  out  32  payload word
Pe_o_src  out  8  packet source
Pe_o_id  out  6  packet id
Pe_o_last  out  1  final word of packet
Err_hdr  out  1  one-cycle pulse: header/dst mismatch or seq_len==0
Err_ovf  out  1  one-cycle pulse: seq_len > MAX_WORDS
Err_timeout  out  1  one-cycle pulse: RECV timeout abort
Pkt_count  out  16  packets delivered, wraps at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state R_IDLE; every output 0; pointers, counters, and captured header 0; buffer contents don't-care.
- States: R_IDLE, R_ACK, R_RECV, R_DRAIN.
- R_IDLE: If_req_rx=1 -> R_ACK. Requests in any other state are ignored and not acked until R_IDLE.
- R_ACK: If_ack_rx=1 for exactly this cycle -> R_RECV. wr_cnt=0, timer=0.
- R_RECV, per valid word:
  - First word (wr_cnt==0) latches src, seq_len, id.
  - seq_len==0 -> Err_hdr pulse, packet dropped, -> R_IDLE.
  - Later words: src, id, or seq_len differing from the latched value -> Err_hdr pulse. The word is still stored and counted.
  - Any word with dst != Node_local_id -> Err_hdr pulse, same rule.
  - Payload written at buf[wr_cnt] only if wr_cnt < MAX_WORDS, then wr_cnt++.
  - When wr_cnt+1 == latched seq_len -> R_DRAIN next cycle.
  - seq_len > MAX_WORDS: Err_ovf pulses once on the first word. Excess words are counted but discarded; drain length = MAX_WORDS.
  - Timer increments on cycles without valid and clears on valid. Timer == TIMEOUT -> Err_timeout pulse, packet discarded, -> R_IDLE.
- R_DRAIN:
  - Pe_o_valid=1 from the first cycle in state, which is the cycle after the last word is captured.
  - Pe_o_data = buf[rd_ptr]; Pe_o_src and Pe_o_id hold the latched header.
  - Pe_o_last=1 when rd_ptr == drain_len-1.
  - Handshake on Pe_o_valid & Pe_i_ready: rd_ptr++. Outputs stay stable while ready is low.
  - Handshake on the last word -> R_IDLE next cycle, Pkt_count++, Pe_o_valid=0.
- Latency: last input word to first Pe_o_valid = 1 cycle. A back-to-back request is acked no sooner than 2 cycles after the final drain handshake (R_IDLE, then R_ACK).
- If_data_input_valid outside R_RECV is ignored and never stored.
- Simultaneous error sources on one word: all applicable pulses assert in the same cycle.
- Reset mid-packet: immediate return to the reset state; no partial packet is delivered.

Test Plan:
1. Local id 8'd4; req, then 3 words src=7 dst=4 seq_len=3 id=5, payloads 0x40200000/0x40800000/0x3F900000, ready=1 -> one ack pulse; Pe_o_data same order one per cycle; last on the 3rd; src 7, id 5; Pkt_count=1.
2. Same packet with Pe_i_ready low for 4 cycles on word 2 -> word 2 held stable; no loss or duplication; Pkt_count=1.
3. seq_len=12, MAX_WORDS=8 -> Err_ovf single pulse on word 1; exactly 8 words delivered, last on the 8th; then R_IDLE.
4. Word 2 carries src=3 instead of 7 -> Err_hdr pulse that cycle; packet still delivered with Pe_o_src=7. Separately, seq_len=0 -> Err_hdr pulse, no Pe_o_valid, back to idle.
5. TIMEOUT=10; 1 of 3 words sent, then valid low -> Err_timeout after 10 idle cycles; no Pe_o_valid; the next req is acked normally.
6. If_req_rx held high during R_DRAIN -> no ack until drain completes. Separately, N_rst low mid-RECV -> all outputs 0 immediately, Pkt_count=0.
